sort_frame_loader: RTL
======================

Name: sort_frame_loader

Overview:
- Upstream feeder for sort_N.
- Collects a serial stream of DATAWIDTH-bit samples into N-entry frames, using two ping-pong banks so intake continues while a completed frame waits.
- Presents each completed frame as one flattened parallel word, registered in the bank, with a valid/ready handshake to the sort network.
- Supports flush of a partial frame, padding the unused entries with a constant.

Parameters:
- DATAWIDTH, 8, data width of each sample.
- N, 16, entries per frame; power of two, N >= 2.
- PAD_VALUE, 0, DATAWIDTH-bit value written into unused entries on flush.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RSTn  input  1  asynchronous active-low reset.
- in_data  input  DATAWIDTH  sample.
- in_valid  input  1  sample present.
- in_ready  output  1  loader can accept a sample this cycle.
- flush  input  1  close the current partial frame.
- frame_data  output  N*DATAWIDTH  frame; entry k at bits [k*DATAWIDTH +: DATAWIDTH]; entry 0 is the first sample accepted.
- frame_valid  output  1  frame_data is valid.
- frame_ready  input  1  sorter consumes the frame.
- frame_fill  output  $clog2(N)+1  number of real (unpadded) entries in the presented frame.

Behaviour:
- Reset:
  - Both banks are cleared to 0; bank_full = 2'b00.
  - wr_bank = 0, rd_bank = 0, wr_idx = 0.
  - Outputs: in_ready = 1, frame_valid = 0, frame_data = 0, frame_fill = 0.
- Reset mid-frame discards any partial or held frames.
- Accept:
  - A sample is accepted when in_valid && in_ready.
  - in_ready = !bank_full[wr_bank].
  - The sample is written to bank[wr_bank][wr_idx], then wr_idx increments.
- Close on full: when the sample accepted is at wr_idx == N-1:
  - bank_full[wr_bank] is set and fill[wr_bank] = N.
  - wr_idx returns to 0 and wr_bank toggles.
- Close on flush: when flush = 1 and the entry count after this cycle's accept is nonzero and less than N:
  - Entries from that count to N-1 are written with PAD_VALUE.
  - fill[wr_bank] is set to the count and bank_full[wr_bank] is set.
  - wr_idx returns to 0 and wr_bank toggles.
- Flush is ignored in these cases:
  - The count is 0, i.e. no partial frame exists. This includes the case where the write bank is full.
  - The accept in the same cycle completes the frame; this is a normal full close with fill = N.
- Present:
  - frame_valid = bank_full[rd_bank].
  - frame_data = bank[rd_bank].
  - frame_fill = fill[rd_bank], or 0 when frame_valid = 0.
  - frame_data and frame_fill are stable while frame_valid is high and frame_ready is low.
- Consume: on frame_valid && frame_ready, bank_full[rd_bank] is cleared and rd_bank toggles the next cycle.
  - frame_ready while frame_valid = 0 has no effect.
- Latency: a frame closed at edge t shows frame_valid = 1 after edge t, i.e. in the next cycle. No combinational path runs from in_* to frame_*.
- Throughput:
  - One sample per cycle is sustained, provided each frame is consumed within N cycles of its presentation.
  - When both banks are full, in_ready = 0 (backpressure). Samples are never dropped or overwritten.
- Simultaneous events: a close on wr_bank and a consume on rd_bank in the same cycle are both honoured.
  - If the other bank was just freed, in_ready stays 1 without a bubble.
- Frame order: frames are always presented in close order.

Test Plan:
1. Reset (N=4, DATAWIDTH=8) -> in_ready = 1, frame_valid = 0, frame_data = 32'h0, frame_fill = 0.
2. Hold frame_ready = 0 and stream 11,22,33,44 back-to-back -> frame_valid = 1 the cycle after 44, frame_data = 32'h44332211, frame_fill = 4. Continue with 55,66,77,88, all accepted -> in_ready = 0 on the next cycle; a 9th sample is not accepted.
3. Continuing from 2, pulse frame_ready for one cycle -> next cycle frame_data = 32'h88776655 and in_ready = 1. Pulse again -> frame_valid = 0.
4. PAD_VALUE = 8'hEE: accept A1,A2, then flush with in_valid = 0 -> frame_data = 32'hEEEEA2A1, frame_fill = 2. Flush with an empty frame -> no frame is produced.
5. Accept B1,B2, then B3 with flush in the same cycle -> frame_data = 32'hEEB3B2B1, frame_fill = 3. Accept C1..C3, then C4 with flush -> frame_fill = 4, no padding.
6. Two frames held, then drop RSTn mid-way through a third frame -> all outputs return to reset values asynchronously. After release, the first new sample lands in entry 0 of bank 0.

Source files
------------

// File: rtl/sort_frame_loader.sv
// sort_frame_loader: gathers a serial sample stream into N-entry frames held in
// two ping-pong banks and presents each closed frame as one flattened word to
// the downstream sort network. A partial frame can be closed early with flush,
// which pads the unused entries with PAD_VALUE.
//
// Handshakes (both sides): a transfer happens on a rising CLK edge where the
// producer's valid and the consumer's ready are both high. Valid never depends
// combinationally on ready, and the presented payload holds steady while
// valid is high and ready is low.
module sort_frame_loader #(
    parameter int                   DATAWIDTH = 8,
    parameter int                   N         = 16,
    parameter logic [DATAWIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic [DATAWIDTH-1:0]      in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [N*DATAWIDTH-1:0]    frame_data,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [$clog2(N):0]        frame_fill
);

    localparam int IW = $clog2(N);
    localparam int FW = IW + 1;

    logic [N*DATAWIDTH-1:0] bank_q [2];
    logic [FW-1:0]          fill_q [2];
    logic [1:0]             bank_full;
    logic                   wr_bank;
    logic                   rd_bank;
    logic [IW-1:0]          wr_idx;

    logic                   accept;
    logic                   consume;
    logic                   close_full;
    logic                   close_flush;
    logic                   close_any;
    logic [FW-1:0]          count_after;
    logic [N*DATAWIDTH-1:0] wr_word;
    logic [1:0]             full_nxt;

    // Output side: everything presented comes straight from registers.
    assign in_ready    = !bank_full[wr_bank];
    assign frame_valid = bank_full[rd_bank];
    assign frame_data  = bank_q[rd_bank];
    assign frame_fill  = frame_valid ? fill_q[rd_bank] : '0;

    // Decide accept/close/consume and build the updated write-bank word.
    always_comb begin
        accept      = in_valid && in_ready;
        consume     = frame_valid && frame_ready;
        count_after = {1'b0, wr_idx} + FW'(accept);
        close_full  = accept && (wr_idx == IW'(N - 1));
        // A flush only matters when a genuine partial frame exists; the full
        // close already covers the case where this accept completes the frame.
        close_flush = flush && !close_full && (count_after != '0);
        close_any   = close_full || close_flush;

        wr_word = bank_q[wr_bank];
        if (accept) begin
            wr_word[int'(wr_idx)*DATAWIDTH +: DATAWIDTH] = in_data;
        end
        for (int k = 0; k < N; k++) begin
            if (close_flush && (FW'(k) >= count_after)) begin
                wr_word[k*DATAWIDTH +: DATAWIDTH] = PAD_VALUE;
            end
        end

        // Close and consume never hit the same bank: closing needs an empty
        // write bank, consuming needs a full read bank.
        full_nxt = bank_full;
        if (consume) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (close_any) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Bank contents and per-bank fill counts.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            fill_q[0] <= '0;
            fill_q[1] <= '0;
        end else begin
            if (accept || close_flush) begin
                bank_q[wr_bank] <= wr_word;
            end
            if (close_any) begin
                fill_q[wr_bank] <= count_after;
            end
        end
    end

    // Bank pointers, write index and full flags.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bank_full <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
        end else begin
            bank_full <= full_nxt;
            if (close_any) begin
                wr_idx  <= '0;
                wr_bank <= !wr_bank;
            end else if (accept) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (consume) begin
                rd_bank <= !rd_bank;
            end
        end
    end

endmodule
